group_index_counter_bank: RTL
=============================

Name: group_index_counter_bank

Overview:
- Bank of NUM_GROUPS independent index counters. Each accepted command selects one group and increments or decrements that group's counter, with either wrap or saturate behaviour.
- Adds a valid/ready command handshake, per-group status flags, and event pulses.
- Adds a multi-cycle clear-all sweep sequencer.
- Sits between the group-select decode logic and the downstream index consumers. Generalised successor of the fixed six-group, 2-bit, increment-only index control.

Parameters:
- NUM_GROUPS, 6, number of independent counters (2..64).
- GROUP_W, 3, width of the group-select field; must satisfy 2**GROUP_W >= NUM_GROUPS.
- IDX_W, 2, width of each counter (1..16).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Cmd_Valid  in  1  command present this cycle.
- Cmd_Ready  out  1  bank can accept a command this cycle.
- Cmd_Group  in  GROUP_W  target group number.
- Cmd_Mode  in  2  bit1: 0=increment, 1=decrement; bit0: 0=wrap, 1=saturate.
- Clear_All  in  1  single-cycle request to zero all counters via sweep.
- Index_Bus  out  NUM_GROUPS*IDX_W  packed counters; group g occupies bits [g*IDX_W +: IDX_W].
- Max_Flags  out  NUM_GROUPS  bit g = 1 when counter g == 2**IDX_W-1.
- Zero_Flags  out  NUM_GROUPS  bit g = 1 when counter g == 0.
- Wrap_Pulse  out  1  one-cycle pulse: last accepted command wrapped.
- Sat_Pulse  out  1  one-cycle pulse: last accepted command was blocked by saturation.
- Err_Pulse  out  1  one-cycle pulse: last accepted command had Cmd_Group >= NUM_GROUPS.
- Busy  out  1  sweep in progress.
- Sweep_Done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (asynchronous, active-high; clock Clk):
  - All counters = 0, so Index_Bus = 0, Zero_Flags all 1, Max_Flags all 0.
  - All pulses = 0, Busy = 0, state = IDLE, sweep pointer = 0.
  - Reset mid-sweep aborts the sweep immediately; Sweep_Done is not pulsed.
- State machine IDLE / SWEEP:
  - IDLE + Clear_All=1 -> SWEEP next edge; sweep pointer = 0.
  - SWEEP: each cycle zero counter[ptr], then ptr++. After ptr == NUM_GROUPS-1 is cleared -> IDLE.
  - Sweep takes exactly NUM_GROUPS cycles.
  - Busy = (state == SWEEP).
  - Sweep_Done is registered and high for one cycle, coincident with the first IDLE cycle.
  - Clear_All while in SWEEP is ignored (no restart).
- Handshake:
  - Cmd_Ready = (state == IDLE) && !Clear_All (combinational). Clear_All has priority over a same-cycle command.
  - A command is accepted when Cmd_Valid && Cmd_Ready at the rising edge.
  - Non-accepted commands have no effect; the source must hold them.
- Command execution (accepted at edge k; new value and pulses visible after edge k, i.e. 1-cycle latency, one command per cycle max):
  - Increment, wrap: max -> 0, Wrap_Pulse = 1.
  - Increment, saturate: at max, value held, Sat_Pulse = 1.
  - Decrement, wrap: 0 -> max, Wrap_Pulse = 1.
  - Decrement, saturate: at 0, value held, Sat_Pulse = 1.
  - Otherwise ±1 modulo 2**IDX_W, pulses 0.
  - Only the selected counter changes; all others hold.
  - Cmd_Group >= NUM_GROUPS: no counter changes, Err_Pulse = 1, Wrap_Pulse = Sat_Pulse = 0.
- Pulses are registered, deasserted the cycle after assertion, and 0 on cycles with no accepted command.
- Flags are combinational decodes of the current counter registers.
- Counters retain their value indefinitely while idle.

Test Plan:
- Reset, then 5 accepted commands Group=2, Mode=00 -> Index_Bus group2 sequence 1,2,3,0,1. Wrap_Pulse high only after the 4th edge. Other groups stay 0.
- Group=4 Mode=01 ×4 -> counter4 = 3 after 3 commands, Max_Flags[4] = 1. 4th command: value stays 3, Sat_Pulse = 1, Wrap_Pulse = 0.
- Group=1 Mode=10 from 0 -> counter1 = 3, Wrap_Pulse = 1. Then Mode=11 ×3 -> 2,1,0. One more Mode=11 -> stays 0, Sat_Pulse = 1, Zero_Flags[1] = 1.
- Load counters to nonzero, then pulse Clear_All with Cmd_Valid=1 the same cycle:
  - Cmd_Ready = 0 and the command is dropped.
  - Busy high for exactly 6 cycles; counters zero in order 0..5, one per cycle.
  - Sweep_Done pulses once; Cmd_Ready returns to 1.
  - Clear_All re-asserted mid-sweep has no effect.
- Cmd_Group = 6 and 7 with Cmd_Valid = 1 -> Err_Pulse = 1 each, Index_Bus unchanged.
- Assert Reset asynchronously mid-sweep and mid-count -> outputs go to reset values before the next edge; no Sweep_Done; next command behaves as from 0.

Source files
------------

// File: rtl/group_index_counter_bank.sv
// Bank of independent index counters driven by a valid/ready command port.
// Each counter can wrap or saturate, and a multi-cycle sweep clears the whole bank.
module group_index_counter_bank #(
   parameter int unsigned NUM_GROUPS = 6,
   parameter int unsigned GROUP_W    = 3,
   parameter int unsigned IDX_W      = 2
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        Cmd_Valid,
   output logic                        Cmd_Ready,
   input  logic [GROUP_W-1:0]          Cmd_Group,
   input  logic [1:0]                  Cmd_Mode,
   input  logic                        Clear_All,
   output logic [NUM_GROUPS*IDX_W-1:0] Index_Bus,
   output logic [NUM_GROUPS-1:0]       Max_Flags,
   output logic [NUM_GROUPS-1:0]       Zero_Flags,
   output logic                        Wrap_Pulse,
   output logic                        Sat_Pulse,
   output logic                        Err_Pulse,
   output logic                        Busy,
   output logic                        Sweep_Done
);

   localparam logic [GROUP_W:0]   NG       = (GROUP_W+1)'(NUM_GROUPS);
   localparam logic [GROUP_W-1:0] LAST_PTR = GROUP_W'(NUM_GROUPS-1);
   localparam logic [IDX_W-1:0]   IDX_MAX  = '1;

   typedef enum logic {IDLE, SWEEP} state_e;

   state_e             state_q, state_d;
   logic [GROUP_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0]   cnt_q [NUM_GROUPS];
   logic [IDX_W-1:0]   cnt_d [NUM_GROUPS];
   logic               wrap_q, wrap_d;
   logic               sat_q, sat_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic accept;
   logic grp_ok;
   logic dec, sat_mode, at_end;

   assign Cmd_Ready = (state_q == IDLE) && !Clear_All;
   assign accept    = Cmd_Valid && Cmd_Ready;
   assign grp_ok    = ({1'b0, Cmd_Group} < NG);
   assign dec       = Cmd_Mode[1];
   assign sat_mode  = Cmd_Mode[0];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (Clear_All) begin
               state_d = SWEEP;
               ptr_d   = '0;
            end
         end
         SWEEP: begin
            if (ptr_q == LAST_PTR) begin
               state_d = IDLE;
               ptr_d   = '0;
               done_d  = 1'b1;
            end else begin
               ptr_d = ptr_q + GROUP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Sweep and commands never overlap: commands are only accepted in IDLE.
   always_comb begin
      wrap_d = 1'b0;
      sat_d  = 1'b0;
      err_d  = accept && !grp_ok;
      at_end = 1'b0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
         cnt_d[g] = cnt_q[g];
         if (state_q == SWEEP && ptr_q == GROUP_W'(g)) begin
            cnt_d[g] = '0;
         end else if (accept && grp_ok && Cmd_Group == GROUP_W'(g)) begin
            at_end = dec ? (cnt_q[g] == '0) : (cnt_q[g] == IDX_MAX);
            if (at_end && sat_mode) begin
               sat_d = 1'b1;
            end else begin
               wrap_d   = at_end;
               cnt_d[g] = dec ? cnt_q[g] - IDX_W'(1) : cnt_q[g] + IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '{default: '0};
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      Index_Bus  = '0;
      Max_Flags  = '0;
      Zero_Flags = '0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
         Index_Bus[g*IDX_W +: IDX_W] = cnt_q[g];
         Max_Flags[g]                = (cnt_q[g] == IDX_MAX);
         Zero_Flags[g]               = (cnt_q[g] == '0);
      end
   end

   assign Wrap_Pulse = wrap_q;
   assign Sat_Pulse  = sat_q;
   assign Err_Pulse  = err_q;
   assign Busy       = (state_q == SWEEP);
   assign Sweep_Done = done_q;

endmodule
